// File: rtl/id_ex_elastic.sv
// ID/EX elastic stage: valid/ready handshake with a 2-entry skid buffer,
// synchronous flush and a saturating back-pressure counter.
module id_ex_elastic #(
    parameter int DATA_WIDTH = 32,
    parameter int SB_WIDTH   = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  clr_cnt_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] inst_i,
    input  logic [DATA_WIDTH-1:0] rs1_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    input  logic [SB_WIDTH-1:0]   sb_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [DATA_WIDTH-1:0] rs1_o,
    output logic [DATA_WIDTH-1:0] rs2_o,
    output logic [DATA_WIDTH-1:0] imm_o,
    output logic [SB_WIDTH-1:0]   sb_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
        logic [DATA_WIDTH-1:0] rs1;
        logic [DATA_WIDTH-1:0] rs2;
        logic [DATA_WIDTH-1:0] imm;
        logic [SB_WIDTH-1:0]   sb;
    } beat_t;

    beat_t                in_beat;
    beat_t                out_q;
    beat_t                skid_q;
    logic                 out_v;
    logic                 skid_v;
    logic                 in_fire;
    logic                 out_free;
    logic [CNT_WIDTH-1:0] cnt;

    assign in_beat  = '{pc: pc_i, inst: inst_i, rs1: rs1_i,
                        rs2: rs2_i, imm: imm_i, sb: sb_i};

    // Ready depends only on held state, never on out_ready_i.
    assign in_ready_o = !skid_v && !rst_i;
    assign in_fire    = in_valid_i && in_ready_o;
    assign out_free   = !out_v || out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            out_q  <= '0;
            skid_q <= '0;
            cnt    <= '0;
        end else begin
            if (flush_i) begin
                out_v  <= 1'b0;
                skid_v <= 1'b0;
            end else if (out_free) begin
                if (skid_v) begin
                    out_q  <= skid_q;
                    out_v  <= 1'b1;
                    skid_v <= 1'b0;
                end else begin
                    out_v <= in_fire;
                    if (in_fire) out_q <= in_beat;
                end
            end else if (in_fire) begin
                skid_q <= in_beat;
                skid_v <= 1'b1;
            end

            if (clr_cnt_i) begin
                cnt <= '0;
            end else if (out_v && !out_ready_i && cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign out_valid_o = out_v;
    assign pc_o        = out_q.pc;
    assign inst_o      = out_q.inst;
    assign rs1_o       = out_q.rs1;
    assign rs2_o       = out_q.rs2;
    assign imm_o       = out_q.imm;
    assign sb_o        = out_q.sb;
    assign stall_cnt_o = cnt;

endmodule

// File: tb/tb_id_ex_elastic.sv
// Bench for id_ex_elastic: scoreboard of accepted beats plus
// per-scenario directed checks of handshake, flush, reset and counter.
module tb_id_ex_elastic;

    localparam int DW = 32;
    localparam int SW = 8;
    localparam int CW = 4;
    localparam int BW = 5 * DW + SW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] pc_i = '0;
    logic [DW-1:0] inst_i = '0;
    logic [DW-1:0] rs1_i = '0;
    logic [DW-1:0] rs2_i = '0;
    logic [DW-1:0] imm_i = '0;
    logic [SW-1:0] sb_i = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] pc_o;
    logic [DW-1:0] inst_o;
    logic [DW-1:0] rs1_o;
    logic [DW-1:0] rs2_o;
    logic [DW-1:0] imm_o;
    logic [SW-1:0] sb_o;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int failures = 0;
    logic [BW-1:0] exp_q[$];

    id_ex_elastic #(
        .DATA_WIDTH(DW),
        .SB_WIDTH  (SW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .clr_cnt_i  (clr),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .pc_i       (pc_i),
        .inst_i     (inst_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .imm_i      (imm_i),
        .sb_i       (sb_i),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .pc_o       (pc_o),
        .inst_o     (inst_o),
        .rs1_o      (rs1_o),
        .rs2_o      (rs2_o),
        .imm_o      (imm_o),
        .sb_o       (sb_o),
        .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] mk_beat(input logic [DW-1:0] pc);
        logic [SW-1:0] sb;
        sb = pc[SW-1:0] ^ 8'h3c;
        return {pc, ~pc, pc ^ 32'h5a5a_5a5a, pc + 32'h1000, pc << 2, sb};
    endfunction

    task automatic drive(input logic v, input logic [DW-1:0] pc);
        logic [BW-1:0] b;
        b        = mk_beat(pc);
        in_valid = v;
        {pc_i, inst_i, rs1_i, rs2_i, imm_i, sb_i} = b;
    endtask

    // Advance one cycle from a negedge; scoreboard tracks accepted beats.
    task automatic tick();
        logic          fin;
        logic          fout;
        logic [BW-1:0] got;
        logic [BW-1:0] exp;
        #1;
        fin  = in_valid && in_ready;
        fout = out_valid && out_ready;
        got  = {pc_o, inst_o, rs1_o, rs2_o, imm_o, sb_o};
        if (fout) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got pc=%h required none", pc_o);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("FAIL sb_beat got=%h required=%h", got, exp);
                end
            end
        end
        if (rst || flush) exp_q.delete();
        else if (fin) exp_q.push_back({pc_i, inst_i, rs1_i, rs2_i, imm_i, sb_i});
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, '0);
        tick();
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_ready got=%b required=0", in_ready);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({in_ready, out_valid, stall_cnt, pc_o, sb_o} !== {1'b1, 1'b0, 4'd0, 32'd0, 8'd0}) begin
            failures++;
            $display("FAIL reset_state got rdy=%b v=%b cnt=%0d pc=%h sb=%h required 1 0 0 0 0",
                     in_ready, out_valid, stall_cnt, pc_o, sb_o);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(1'b1, 32'h100);
        tick();
        checks++;
        if (out_valid !== 1'b1 || pc_o !== 32'h100 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL single got v=%b pc=%h rdy=%b required 1 00000100 1",
                     out_valid, pc_o, in_ready);
        end
        drive(1'b0, '0);
        tick();
        checks++;
        if (out_valid !== 1'b0 || stall_cnt !== 4'd0) begin
            failures++;
            $display("FAIL single_drain got v=%b cnt=%0d required 0 0", out_valid, stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, DW'(i * 4));
            tick();
            checks++;
            if (out_valid !== 1'b1 || pc_o !== DW'(i * 4) || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_%0d got v=%b pc=%h rdy=%b required 1 %h 1",
                         i, out_valid, pc_o, in_ready, DW'(i * 4));
            end
        end
        drive(1'b0, '0);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got v=%b required 0", out_valid);
        end
    endtask

    task automatic test_skid();
        out_ready = 1'b1;
        drive(1'b1, 32'h10);
        tick();
        out_ready = 1'b0;
        drive(1'b1, 32'h14);
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || pc_o !== 32'h10) begin
            failures++;
            $display("FAIL skid_fill got rdy=%b v=%b pc=%h required 0 1 00000010",
                     in_ready, out_valid, pc_o);
        end
        drive(1'b0, '0);
        tick();
        checks++;
        if (pc_o !== 32'h10 || stall_cnt !== 4'd2) begin
            failures++;
            $display("FAIL skid_hold got pc=%h cnt=%0d required 00000010 2", pc_o, stall_cnt);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || pc_o !== 32'h14 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL skid_move got v=%b pc=%h rdy=%b required 1 00000014 1",
                     out_valid, pc_o, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL skid_drain got v=%b required 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        drive(1'b1, 32'h20);
        tick();
        out_ready = 1'b0;
        drive(1'b1, 32'h24);
        tick();
        drive(1'b1, 32'h28);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, '0);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_full got v=%b rdy=%b required 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_leak got v=%b pc=%h required 0", out_valid, pc_o);
            end
        end
        drive(1'b1, 32'h2c);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, '0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_in got v=%b pc=%h required 0", out_valid, pc_o);
        end
    endtask

    task automatic test_stall_cnt();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'h30);
        tick();
        out_ready = 1'b0;
        drive(1'b0, '0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 9) begin
                checks++;
                if (stall_cnt !== 4'd10) begin
                    failures++;
                    $display("FAIL cnt_mid got=%0d required=10", stall_cnt);
                end
            end
        end
        checks++;
        if (stall_cnt !== 4'd15 || pc_o !== 32'h30 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL cnt_sat got cnt=%0d pc=%h v=%b required 15 00000030 1",
                     stall_cnt, pc_o, out_valid);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (stall_cnt !== 4'd0) begin
            failures++;
            $display("FAIL cnt_clr got=%0d required=0", stall_cnt);
        end
        tick();
        checks++;
        if (stall_cnt !== 4'd1) begin
            failures++;
            $display("FAIL cnt_after_clr got=%0d required=1", stall_cnt);
        end
        tick();
        flush = 1'b1;
        clr   = 1'b1;
        tick();
        flush = 1'b0;
        clr   = 1'b0;
        checks++;
        if (stall_cnt !== 4'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_clr got cnt=%0d v=%b required 0 0", stall_cnt, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        drive(1'b1, 32'h40);
        tick();
        out_ready = 1'b0;
        drive(1'b1, 32'h44);
        tick();
        drive(1'b1, 32'h48);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_rdy got=%b required=0", in_ready);
        end
        tick();
        checks++;
        if ({out_valid, pc_o, inst_o, rs1_o, rs2_o, imm_o, sb_o, stall_cnt} !== '0) begin
            failures++;
            $display("FAIL rstmid_out got v=%b pc=%h inst=%h sb=%h cnt=%0d required all 0",
                     out_valid, pc_o, inst_o, sb_o, stall_cnt);
        end
        rst = 1'b0;
        drive(1'b0, '0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_after got rdy=%b required 1", in_ready);
        end
        out_ready = 1'b1;
        drive(1'b1, 32'h50);
        tick();
        drive(1'b0, '0);
        tick();
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL rstmid_resume got v=%b pending=%0d required 0 0",
                     out_valid, exp_q.size());
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_skid();
        test_flush();
        test_stall_cnt();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_elastic.md
Name: id_ex_elastic

Overview:
- Parametrised successor of the ID/EX pipeline register.
- Carries pc, inst, rs1, rs2, imm and a generic control sideband from decode to execute.
- Replaces the plain enable with a valid/ready handshake, a 2-entry skid buffer, a synchronous flush for branch squash, and a saturating back-pressure counter.
- Lets execute stall without combinational ready paths reaching back into decode.

Parameters:
- DATA_WIDTH, 32, width of each of pc/inst/rs1/rs2/imm.
- SB_WIDTH, 8, width of the opaque control sideband (alu_op, sel bits, ...) carried with each beat.
- CNT_WIDTH, 16, width of the stall-cycle counter.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  squash all held and incoming beats (branch taken / exception).
- clr_cnt_i  in  1  synchronous clear of the stall counter.
- in_valid_i  in  1  decode presents a beat.
- in_ready_o  out  1  stage can accept a beat.
- pc_i, inst_i, rs1_i, rs2_i, imm_i  in  DATA_WIDTH each  payload in.
- sb_i  in  SB_WIDTH  sideband in.
- out_valid_o  out  1  beat available to execute.
- out_ready_i  in  1  execute accepts the beat.
- pc_o, inst_o, rs1_o, rs2_o, imm_o  out  DATA_WIDTH each  payload out.
- sb_o  out  SB_WIDTH  sideband out.
- stall_cnt_o  out  CNT_WIDTH  cycles with out_valid_o=1 and out_ready_i=0, saturating.

Behaviour:
- State:
  - output register OUT: valid bit + payload, drives *_o directly.
  - skid register SKID: valid bit + payload.
  - stall counter CNT.
- Reset (rst_i=1 at posedge):
  - OUT.valid=0, SKID.valid=0, all payload regs=0, CNT=0.
  - in_ready_o is forced 0 while rst_i=1; it is 1 in the first cycle after reset.
- Handshake events:
  - in_fire = in_valid_i & in_ready_o.
  - out_fire = out_valid_o & out_ready_i.
  - in_ready_o = !SKID.valid & !rst_i. It is a registered-state function and has no combinational path from out_ready_i.
  - out_valid_o = OUT.valid.
- Priority: rst_i > flush_i > normal operation.
- Flush (flush_i=1, rst_i=0):
  - Next cycle OUT.valid=0 and SKID.valid=0.
  - Any in_fire in the flush cycle is discarded.
  - Payload regs hold their old values (don't-care while valid=0).
  - CNT is not affected by the flush itself.
- Normal operation, evaluated per posedge:
  - OUT empty or out_fire, with SKID empty: OUT <= input beat if in_fire, else OUT.valid <= 0.
  - OUT empty or out_fire, with SKID full: OUT <= SKID; SKID.valid <= 0. No in_fire is possible since in_ready_o=0.
  - OUT full and !out_ready_i, with in_fire: SKID <= input beat; in_ready_o drops next cycle.
  - OUT full and !out_ready_i, with no in_fire: hold.
- Timing:
  - Latency 1 cycle, in_fire to out_valid_o.
  - Sustained throughput 1 beat/cycle.
  - In-order delivery; no beat is lost or duplicated except by flush.
- Payload only changes when its register is loaded; *_o are stable while out_valid_o=1 and out_ready_i=0.
- Stall counter:
  - CNT increments when out_valid_o & !out_ready_i.
  - Saturates at 2^CNT_WIDTH-1.
  - clr_cnt_i (or rst_i) sets CNT=0 and takes priority over increment.
- Simultaneous flush_i and clr_cnt_i: both take effect.
- Widths: all payloads are passed unmodified; no sign extension or arithmetic.

Test Plan:
- Reset, then in_valid_i=1 with pc_i=0x100, out_ready_i=1 held -> out_valid_o=1 next cycle, pc_o=0x100; in_ready_o=1 throughout; stall_cnt_o=0.
- Stream pc=0x0,0x4,0x8,0xC back-to-back with out_ready_i=1 -> out_valid_o high 4 consecutive cycles, pc_o in the same order, 1-cycle latency.
- out_ready_i=0 while OUT holds 0x10 and 0x14 is pushed -> 0x14 goes to SKID; in_ready_o=0 next cycle; pc_o stays 0x10; out_ready_i=1 -> pc_o=0x10 accepted, then 0x14 next cycle; in_ready_o returns 1.
- Both registers full (0x20 in OUT, 0x24 in SKID), flush_i=1 with in_valid_i=1 pc=0x28 -> next cycle out_valid_o=0 and in_ready_o=1; 0x28 never appears at the output.
- CNT_WIDTH=4, out_ready_i=0 with OUT valid for 20 cycles -> stall_cnt_o reaches 15 and holds; clr_cnt_i pulse -> 0; next stalled cycle -> 1.
- Full pipeline, rst_i=1 for one cycle mid-stream -> out_valid_o=0, all *_o=0, stall_cnt_o=0 next cycle; in_ready_o=0 during reset and 1 after.
